// File: rtl/nf10_ts_pkg.sv
// Shared constants for the timestamp datapath: stamp width, TUSER field map, stamp type.
package nf10_ts_pkg;

  localparam int unsigned TIMESTAMP_WIDTH = 64;
  localparam int unsigned TS_LSB_DEFAULT  = 64;

  // TUSER field offsets
  localparam int unsigned TUSER_LEN_LSB      = 0;
  localparam int unsigned TUSER_LEN_WIDTH    = 16;
  localparam int unsigned TUSER_SRC_PORT_LSB = 16;
  localparam int unsigned TUSER_DST_PORT_LSB = 24;
  localparam int unsigned TUSER_PORT_WIDTH   = 8;
  localparam int unsigned TUSER_STAMP_LSB    = TS_LSB_DEFAULT;

  typedef logic [TIMESTAMP_WIDTH-1:0] ts_t;

endpackage

// File: rtl/nf10_axis_skid.sv
// Generic two-entry registered skid buffer: primary output register plus one spare.
// Upstream ready is registered and equals "spare register empty".
module nf10_axis_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_spare_valid;
  logic [W-1:0] r_spare_data;
  logic         r_ready;
  logic         w_in_fire;
  logic         w_load;

  assign w_in_fire = i_valid & r_ready;
  // Primary register may take a new beat when empty or when its beat leaves this cycle
  assign w_load    = i_ready | ~r_out_valid;

  // Primary/spare register update; spare always drains before new input enters primary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_spare_valid <= 1'b0;
      r_spare_data  <= '0;
      r_ready       <= 1'b0;
    end else if (w_load) begin
      if (r_spare_valid) begin
        r_out_data    <= r_spare_data;
        r_out_valid   <= 1'b1;
        r_spare_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out_data <= i_data;
      end
      r_ready <= 1'b1;
    end else if (w_in_fire) begin
      r_spare_data  <= i_data;
      r_spare_valid <= 1'b1;
      r_ready       <= 1'b0;
    end else begin
      r_ready <= ~r_spare_valid;
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_out_data;
  assign o_valid = r_out_valid;

endmodule

// File: rtl/nf10_axis_rx_timestamp.sv
// Ingress AXI4-Stream stage: writes stamp_counter into TUSER of each packet's first beat.
// Optional feature macro: TS_LATENCY_COMP_EN (stamp = stamp_counter - LATENCY_COMP).
module nf10_axis_rx_timestamp #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned TIMESTAMP_WIDTH      = nf10_ts_pkg::TIMESTAMP_WIDTH,
  parameter int unsigned TS_LSB               = nf10_ts_pkg::TUSER_STAMP_LSB,
  parameter int unsigned LATENCY_COMP         = 0
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [TIMESTAMP_WIDTH-1:0]        stamp_counter,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pkt_count
);

  localparam int unsigned STRB_W    = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned PAYLOAD_W = 1 + STRB_W + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH;

  logic                            r_sop;
  logic [31:0]                     r_pkt_count;
  logic [TIMESTAMP_WIDTH-1:0]      w_stamp;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic                            w_s_ready;
  logic                            w_in_fire;
  logic [PAYLOAD_W-1:0]            w_s_payload;
  logic [PAYLOAD_W-1:0]            w_m_payload;

  assign w_in_fire = s_axis_tvalid & w_s_ready;

`ifdef TS_LATENCY_COMP_EN
  // Back-date the stamp by the MAC/PHY ingress delay, wrapping modulo 2^TIMESTAMP_WIDTH
  assign w_stamp = stamp_counter - TIMESTAMP_WIDTH'(LATENCY_COMP);
`else
  logic w_unused_latency;
  assign w_unused_latency = ^32'(LATENCY_COMP);
  assign w_stamp          = stamp_counter;
`endif

  // Overwrite the stamp field on the first beat only; all other TUSER bits pass through
  always_comb begin
    w_tuser = s_axis_tuser;
    if (r_sop) w_tuser[TS_LSB +: TIMESTAMP_WIDTH] = w_stamp;
  end

  assign w_s_payload = {s_axis_tlast, s_axis_tstrb, w_tuser, s_axis_tdata};

  // Start-of-packet tracking from accepted beats
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn)    r_sop <= 1'b1;
    else if (w_in_fire) r_sop <= s_axis_tlast;
  end

  // Count packets accepted at the input (wraps naturally)
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn)                    r_pkt_count <= 32'd0;
    else if (w_in_fire && s_axis_tlast) r_pkt_count <= r_pkt_count + 32'd1;
  end

  nf10_axis_skid #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk     (axi_aclk),
    .rst_n   (axi_resetn),
    .i_data  (w_s_payload),
    .i_valid (s_axis_tvalid),
    .o_ready (w_s_ready),
    .o_data  (w_m_payload),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

  assign s_axis_tready = w_s_ready;
  assign {m_axis_tlast, m_axis_tstrb, m_axis_tuser, m_axis_tdata} = w_m_payload;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_nf10_axis_rx_timestamp.sv
// Directed bench for nf10_axis_rx_timestamp, plus a randomised-backpressure scoreboard run.
module tb_nf10_axis_rx_timestamp;
  import nf10_ts_pkg::*;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned SW = 32;
  localparam int unsigned PW = 1 + SW + UW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  ts_t           stamp_counter = '0;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [31:0]   pkt_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  nf10_axis_rx_timestamp #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .TIMESTAMP_WIDTH      (64),
    .TS_LSB               (64),
    .LATENCY_COMP         (8)
  ) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .stamp_counter (stamp_counter),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_data(int unsigned k);
    return {8{32'(k)}};
  endfunction

  function automatic logic [UW-1:0] mk_user(int unsigned k);
    return {32'h5555_0000, 32'(k), 32'hCAFE_0000, 32'(k)};
  endfunction

  function automatic logic [SW-1:0] mk_strb(logic last);
    return last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
  endtask

  task automatic set_beat(int unsigned k, logic last);
    s_tvalid = 1'b1;
    s_tdata  = mk_data(k);
    s_tstrb  = mk_strb(last);
    s_tuser  = mk_user(k);
    s_tlast  = last;
  endtask

  task automatic do_reset();
    idle_inputs();
    m_tready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    m_tready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
    vec_cnt++;
    if (s_tready !== 1'b0) begin err_cnt++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    vec_cnt++;
    if (pkt_count !== 32'd0) begin err_cnt++; $display("FAIL reset_pkt_count: got %h want 0", pkt_count); end
    vec_cnt++;
    if ({m_tlast, m_tstrb, m_tuser, m_tdata} !== '0) begin
      err_cnt++; $display("FAIL reset_data: got %h want 0", {m_tlast, m_tstrb, m_tuser, m_tdata});
    end
    tick();
    #2 rst_n = 1'b1;
    vec_cnt++;
    if (s_tready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready_before_edge: got %b want 0", s_tready); end
    tick();
    vec_cnt++;
    if (s_tready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready_after_edge: got %b want 1", s_tready); end
    vec_cnt++;
    if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_idle_valid: got %b want 0", m_tvalid); end
  endtask

  task automatic test_back_to_back();
    logic [PW:0]   got, exp;
    logic [UW-1:0] eu;
    logic          last;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      last = (i % 3 == 2);
      set_beat(100 + i, last);
      stamp_counter = 64'h1000 + 64'(i);
      tick();
      eu = mk_user(100 + i);
      if (i == 0) eu[127:64] = 64'h1000;
      if (i == 3) eu[127:64] = 64'h1003;
      got = {m_tvalid, m_tlast, m_tstrb, m_tuser, m_tdata};
      exp = {1'b1, last, mk_strb(last), eu, mk_data(100 + i)};
      vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, exp); end
    end
    idle_inputs();
    vec_cnt++;
    if (pkt_count !== 32'd2) begin err_cnt++; $display("FAIL b2b_pkt_count: got %0d want 2", pkt_count); end
    tick();
    vec_cnt++;
    if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain: got %b want 0", m_tvalid); end
  endtask

  task automatic test_single_beat();
    logic [UW-1:0] eu;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_beat(200 + i, 1'b1);
      stamp_counter = 64'h2000 + 64'(i);
      tick();
      eu = {64'h2000 + 64'(i), 32'hCAFE_0000, 32'(200 + i)};
      vec_cnt++;
      if ({m_tvalid, m_tlast, m_tuser} !== {1'b1, 1'b1, eu}) begin
        err_cnt++; $display("FAIL single_beat%0d: got %h want %h", i, {m_tvalid, m_tlast, m_tuser}, {1'b1, 1'b1, eu});
      end
    end
    idle_inputs();
    vec_cnt++;
    if (pkt_count !== 32'd4) begin err_cnt++; $display("FAIL single_pkt_count: got %0d want 4", pkt_count); end
  endtask

  task automatic test_stall();
    logic [PW:0] exp_a, exp_b, exp_c, got;
    exp_a = {1'b1, 1'b1, mk_strb(1'b1), 64'h3001, 32'hCAFE_0000, 32'd1, mk_data(1)};
    exp_b = {1'b1, 1'b1, mk_strb(1'b1), 64'h3002, 32'hCAFE_0000, 32'd2, mk_data(2)};
    exp_c = {1'b1, 1'b0, mk_strb(1'b0), 64'h3009, 32'hCAFE_0000, 32'd3, mk_data(3)};
    do_reset();
    m_tready = 1'b0;
    set_beat(1, 1'b1); stamp_counter = 64'h3001; tick();
    got = {m_tvalid, m_tlast, m_tstrb, m_tuser, m_tdata};
    vec_cnt++;
    if (got !== exp_a) begin err_cnt++; $display("FAIL stall_first: got %h want %h", got, exp_a); end
    set_beat(2, 1'b1); stamp_counter = 64'h3002; tick();
    vec_cnt++;
    if (s_tready !== 1'b0) begin err_cnt++; $display("FAIL stall_ready_drop: got %b want 0", s_tready); end
    set_beat(3, 1'b0);
    for (int k = 3; k <= 7; k++) begin
      stamp_counter = 64'h3000 + 64'(k);
      tick();
      got = {m_tvalid, m_tlast, m_tstrb, m_tuser, m_tdata};
      vec_cnt++;
      if (got !== exp_a || s_tready !== 1'b0) begin
        err_cnt++; $display("FAIL stall_hold%0d: got %h ready %b want %h ready 0", k, got, s_tready, exp_a);
      end
    end
    m_tready = 1'b1; stamp_counter = 64'h3008; tick();
    got = {m_tvalid, m_tlast, m_tstrb, m_tuser, m_tdata};
    vec_cnt++;
    if (got !== exp_b || s_tready !== 1'b1) begin
      err_cnt++; $display("FAIL stall_spare_drain: got %h ready %b want %h ready 1", got, s_tready, exp_b);
    end
    stamp_counter = 64'h3009; tick();
    got = {m_tvalid, m_tlast, m_tstrb, m_tuser, m_tdata};
    vec_cnt++;
    if (got !== exp_c) begin err_cnt++; $display("FAIL stall_accept_stamp: got %h want %h", got, exp_c); end
    idle_inputs(); tick();
    vec_cnt++;
    if (m_tvalid !== 1'b0) begin err_cnt++; $display("FAIL stall_end_valid: got %b want 0", m_tvalid); end
    vec_cnt++;
    if (pkt_count !== 32'd2) begin err_cnt++; $display("FAIL stall_pkt_count: got %0d want 2", pkt_count); end
  endtask

  task automatic test_random();
    logic [PW-1:0] q[$];
    logic [PW-1:0] exp_p, got_p;
    ts_t           ts;
    int            pkts_sent, beat_in_pkt, pkt_len, cycles;
    logic          model_sop, in_acc, out_acc;
    do_reset();
    ts = 64'h9000_0000_0000_0000;
    pkts_sent = 0; beat_in_pkt = 0; pkt_len = 1; cycles = 0; model_sop = 1'b1;
    while ((pkts_sent < 1000 || q.size() != 0) && cycles < 40000) begin
      m_tready = 1'($urandom_range(0, 1));
      if (!s_tvalid && pkts_sent < 1000) begin
        if (beat_in_pkt == 0) pkt_len = $urandom_range(1, 4);
        for (int j = 0; j < 8; j++) s_tdata[j*32 +: 32] = $urandom;
        for (int j = 0; j < 4; j++) s_tuser[j*32 +: 32] = $urandom;
        s_tstrb  = $urandom;
        s_tlast  = (beat_in_pkt == pkt_len - 1);
        s_tvalid = 1'b1;
      end
      stamp_counter = ts;
      out_acc = m_tvalid && m_tready;
      in_acc  = s_tvalid && s_tready;
      if (out_acc) begin
        vec_cnt++;
        if (q.size() == 0) begin
          err_cnt++; $display("FAIL rand_extra_beat: got %h want no beat", {m_tlast, m_tstrb, m_tuser, m_tdata});
        end else begin
          exp_p = q.pop_front();
          got_p = {m_tlast, m_tstrb, m_tuser, m_tdata};
          if (got_p !== exp_p) begin err_cnt++; $display("FAIL rand_beat: got %h want %h", got_p, exp_p); end
        end
      end
      if (in_acc) begin
        exp_p = {s_tlast, s_tstrb, s_tuser, s_tdata};
        if (model_sop) exp_p[320 +: 64] = ts;
        q.push_back(exp_p);
        model_sop = s_tlast;
        if (s_tlast) begin pkts_sent++; beat_in_pkt = 0; end
        else beat_in_pkt++;
      end
      tick();
      cycles++;
      ts = ts + 64'($urandom_range(1, 3));
      if (in_acc) s_tvalid = 1'b0;
    end
    idle_inputs();
    m_tready = 1'b1;
    vec_cnt++;
    if (cycles >= 40000) begin err_cnt++; $display("FAIL rand_timeout: got %0d beats pending want 0", q.size()); end
    vec_cnt++;
    if (pkt_count !== 32'd1000) begin err_cnt++; $display("FAIL rand_pkt_count: got %0d want 1000", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    logic [UW-1:0] eu;
    do_reset();
    set_beat(50, 1'b1); stamp_counter = 64'h4000; tick();
    set_beat(51, 1'b0); stamp_counter = 64'h4001; tick();
    set_beat(52, 1'b0); stamp_counter = 64'h4002; tick();
    vec_cnt++;
    if (pkt_count !== 32'd1) begin err_cnt++; $display("FAIL rmid_pre_count: got %0d want 1", pkt_count); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({m_tvalid, s_tready, pkt_count} !== {1'b0, 1'b0, 32'd0} || m_tuser !== '0) begin
      err_cnt++; $display("FAIL rmid_async: got valid %b ready %b count %0d tuser %h want 0 0 0 0",
                          m_tvalid, s_tready, pkt_count, m_tuser);
    end
    idle_inputs();
    tick();
    #2 rst_n = 1'b1;
    tick();
    set_beat(53, 1'b0); stamp_counter = 64'h4010; tick();
    eu = {64'h4010, 32'hCAFE_0000, 32'd53};
    vec_cnt++;
    if ({m_tvalid, m_tuser} !== {1'b1, eu}) begin
      err_cnt++; $display("FAIL rmid_sop_stamp: got %h want %h", {m_tvalid, m_tuser}, {1'b1, eu});
    end
    vec_cnt++;
    if (pkt_count !== 32'd0) begin err_cnt++; $display("FAIL rmid_pkt_count: got %0d want 0", pkt_count); end
    idle_inputs(); tick();
  endtask

  task automatic test_latency_comp();
    ts_t exp_ts;
`ifdef TS_LATENCY_COMP_EN
    exp_ts = 64'hFFFF_FFFF_FFFF_FFFB;
`else
    exp_ts = 64'h3;
`endif
    do_reset();
    set_beat(60, 1'b1); stamp_counter = 64'h3; tick();
    vec_cnt++;
    if (m_tuser !== {exp_ts, 32'hCAFE_0000, 32'd60}) begin
      err_cnt++; $display("FAIL latency_stamp: got %h want %h", m_tuser, {exp_ts, 32'hCAFE_0000, 32'd60});
    end
    idle_inputs(); tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_beat();
    test_stall();
    test_random();
    test_reset_mid_packet();
    test_latency_comp();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
